// File: rtl/hyperbus_w_serializer.sv
// Serializes AXI W beats into 16-bit HyperBus PHY write words with RWDS byte masks.
// Each beat's byte window follows the AXI narrow/unaligned addressing rules for the transfer.
module hyperbus_w_serializer #(
  parameter int AxiDataWidth = 128,
  localparam int NumLanes = AxiDataWidth / 8,
  localparam int LaneIdxW = $clog2(NumLanes)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trans_valid_i,
  output logic                    trans_ready_o,
  input  logic [LaneIdxW-1:0]     trans_offset_i,
  input  logic [2:0]              trans_size_i,
  input  logic [7:0]              trans_len_i,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [NumLanes-1:0]     w_strb_i,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [15:0]             tx_data_o,
  output logic [1:0]              tx_mask_o,
  output logic                    tx_last_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [2:0] MaxSize = 3'(LaneIdxW);
  localparam logic [LaneIdxW-1:0] One = LaneIdxW'(1);
  localparam logic [LaneIdxW-1:0] Two = LaneIdxW'(2);

  state_t                  state;
  logic [LaneIdxW-1:0]     addr;
  logic [LaneIdxW-1:0]     ptr;
  logic [LaneIdxW-1:0]     hi;
  logic [2:0]              size;
  logic [7:0]              beats_left;
  logic [AxiDataWidth-1:0] data_q;
  logic [NumLanes-1:0]     strb_q;
  logic                    err;

  logic                    last_word;
  logic                    final_beat;
  logic                    w_hs;
  logic [LaneIdxW-1:0]     ptr_odd;
  logic [LaneIdxW-1:0]     next_addr;

  // Bits below the beat size; a shift of the full width yields zero, giving an all-ones mask.
  function automatic logic [LaneIdxW-1:0] low_mask(input logic [2:0] sz);
    return ~({LaneIdxW{1'b1}} << sz);
  endfunction

  function automatic logic [LaneIdxW-1:0] lo_of(input logic [LaneIdxW-1:0] a);
    return a & ~One;
  endfunction

  function automatic logic [LaneIdxW-1:0] hi_of(input logic [LaneIdxW-1:0] a,
                                                input logic [2:0] sz);
    return a | low_mask(sz) | One;
  endfunction

  assign last_word  = (ptr[LaneIdxW-1:1] == hi[LaneIdxW-1:1]);
  assign final_beat = (beats_left == 8'd0);
  assign ptr_odd    = ptr | One;
  // Aligned base plus the beat size, wrapping naturally within the bus word.
  assign next_addr  = (addr | low_mask(size)) + One;
  assign w_hs       = w_valid_i && w_ready_o;

  assign trans_ready_o = (state == IDLE);
  assign w_ready_o     = (state == LOAD) ||
                         ((state == SEND) && last_word && tx_ready_i && !final_beat);
  assign tx_valid_o    = (state == SEND);
  assign tx_last_o     = (state == SEND) && last_word && final_beat;
  assign tx_data_o     = (state == SEND) ?
                         {data_q[{ptr_odd, 3'b000} +: 8], data_q[{ptr, 3'b000} +: 8]} : 16'd0;
  assign tx_mask_o     = (state == SEND) ? ~{strb_q[ptr_odd], strb_q[ptr]} : 2'b00;
  assign err_o         = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr       <= '0;
      ptr        <= '0;
      hi         <= '0;
      size       <= '0;
      beats_left <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trans_valid_i) begin
            addr       <= trans_offset_i;
            size       <= (trans_size_i > MaxSize) ? MaxSize : trans_size_i;
            beats_left <= trans_len_i;
            err        <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            data_q <= w_data_i;
            strb_q <= w_strb_i;
            ptr    <= lo_of(addr);
            hi     <= hi_of(addr, size);
            if (w_last_i != final_beat) err <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            if (!last_word) begin
              ptr <= ptr + Two;
            end else if (final_beat) begin
              state <= IDLE;
            end else begin
              beats_left <= beats_left - 8'd1;
              addr       <= next_addr;
              // A beat accepted alongside the outgoing word is the next one, so it is
              // the final beat exactly when one beat remains before the decrement.
              if (w_hs) begin
                data_q <= w_data_i;
                strb_q <= w_strb_i;
                ptr    <= lo_of(next_addr);
                hi     <= hi_of(next_addr, size);
                if (w_last_i != (beats_left == 8'd1)) err <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_w_serializer.sv
// Randomized and directed bench for hyperbus_w_serializer, checked against a byte-window
// model that expands each transfer into the list of expected PHY words.
module tb_hyperbus_w_serializer;

  localparam int AxiDataWidth = 128;
  localparam int NumLanes = AxiDataWidth / 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         trans_valid_i;
  logic         trans_ready_o;
  logic [3:0]   trans_offset_i;
  logic [2:0]   trans_size_i;
  logic [7:0]   trans_len_i;
  logic [127:0] w_data_i;
  logic [15:0]  w_strb_i;
  logic         w_last_i;
  logic         w_valid_i;
  logic         w_ready_o;
  logic [15:0]  tx_data_o;
  logic [1:0]   tx_mask_o;
  logic         tx_last_o;
  logic         tx_valid_o;
  logic         tx_ready_i;
  logic         err_o;

  hyperbus_w_serializer #(.AxiDataWidth(AxiDataWidth)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
    .trans_offset_i(trans_offset_i), .trans_size_i(trans_size_i), .trans_len_i(trans_len_i),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .tx_data_o(tx_data_o), .tx_mask_o(tx_mask_o), .tx_last_o(tx_last_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mask;
    logic        last;
    logic        beat_end;
  } word_t;

  word_t        exp_q[$];
  logic [127:0] beat_data[$];
  logic [15:0]  beat_strb[$];
  int           total = 0;
  int           bad = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expand a transfer into PHY words from plain byte-address arithmetic.
  task automatic buildModel(input int offset, input int size, input int len);
    int addr, sz, base, lo, hi;
    logic [127:0] d;
    logic [15:0] s;
    word_t w;
    exp_q.delete();
    addr = offset;
    sz = (size > 4) ? 4 : size;
    for (int b = 0; b <= len; b++) begin
      base = addr - (addr % (1 << sz));
      lo   = addr - (addr % 2);
      hi   = (sz == 0) ? lo + 1 : base + (1 << sz) - 1;
      d = beat_data[b];
      s = beat_strb[b];
      for (int p = lo; p < hi; p += 2) begin
        w.data     = {d[(p+1)*8 +: 8], d[p*8 +: 8]};
        w.mask     = {~s[p+1], ~s[p]};
        w.beat_end = (p + 1 == hi);
        w.last     = w.beat_end && (b == len);
        exp_q.push_back(w);
      end
      addr = (base + (1 << sz)) % NumLanes;
    end
  endtask

  task automatic fillRandom(input int len);
    beat_data.delete();
    beat_strb.delete();
    for (int b = 0; b <= len; b++) begin
      beat_data.push_back({$urandom, $urandom, $urandom, $urandom});
      beat_strb.push_back(16'($urandom));
    end
  endtask

  // mode 0: random ready/valid, 1: everything held ready/valid, 2: five-cycle stall on word 3.
  task automatic applyStimulus(input int offset, input int size, input int len,
                               input int mode, input bit bad_last);
    int beat_idx, cycles, stall, words_seen, nwords, first_tx, last_tx;
    bit done, prev_w_hs, w_hs, exp_wr;
    word_t head;
    buildModel(offset, size, len);
    nwords = exp_q.size();
    beat_idx = 0; cycles = 0; stall = 0; words_seen = 0;
    first_tx = -1; last_tx = -1; done = 0; prev_w_hs = 0;

    @(negedge clk_i);
    trans_valid_i  = 1'b1;
    trans_offset_i = 4'(offset);
    trans_size_i   = 3'(size);
    trans_len_i    = 8'(len);
    w_valid_i      = 1'b0;
    tx_ready_i     = 1'b0;
    #1;
    checkOutput("trans_ready_idle", trans_ready_o, 1'b1);

    while (!done && cycles < 2000) begin
      @(negedge clk_i);
      trans_valid_i = 1'b0;
      cycles++;
      if (beat_idx <= len) begin
        w_valid_i = (mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        w_data_i  = beat_data[beat_idx];
        w_strb_i  = beat_strb[beat_idx];
        w_last_i  = (beat_idx == len) ^ (bad_last && beat_idx == 0);
      end else begin
        w_valid_i = 1'b0;
      end
      if (mode == 0) tx_ready_i = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && words_seen == 3 && stall < 5) begin
        tx_ready_i = 1'b0;
        stall++;
      end else tx_ready_i = 1'b1;
      #1;
      if (prev_w_hs) checkOutput("first_word_latency", tx_valid_o, 1'b1);
      if (tx_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_tx_word", tx_valid_o, 1'b0);
          done = 1;
        end else begin
          head = exp_q[0];
          exp_wr = head.beat_end && !head.last && tx_ready_i;
          checkOutput("tx_data", tx_data_o, head.data);
          checkOutput("tx_mask", tx_mask_o, head.mask);
          checkOutput("tx_last", tx_last_o, head.last);
          checkOutput("w_ready_send", w_ready_o, exp_wr);
          if (tx_ready_i) begin
            void'(exp_q.pop_front());
            words_seen++;
            if (first_tx < 0) first_tx = cycles;
            last_tx = cycles;
            if (head.last) done = 1;
          end
        end
      end else begin
        checkOutput("tx_last_idle", tx_last_o, 1'b0);
        checkOutput("w_ready_load", w_ready_o, 1'b1);
      end
      w_hs = w_valid_i && w_ready_o;
      if (w_hs) beat_idx++;
      prev_w_hs = w_hs;
    end

    if (!done) checkOutput("transfer_timeout", 1'b0, 1'b1);
    if (mode == 1) checkOutput("no_bubble_span", last_tx - first_tx + 1, nwords);
    @(negedge clk_i);
    w_valid_i = 1'b0;
    #1;
    checkOutput("words_emitted", words_seen, nwords);
    checkOutput("beats_consumed", beat_idx, len + 1);
    checkOutput("back_to_idle", trans_ready_o, 1'b1);
    checkOutput("tx_valid_idle", tx_valid_o, 1'b0);
    checkOutput("err_flag", err_o, bad_last);
  endtask

  // Start a bad-last transfer, then reset it in the middle of SEND.
  task automatic resetMidTransfer();
    int cycles, words_seen;
    fillRandom(3);
    @(negedge clk_i);
    trans_valid_i = 1'b1; trans_offset_i = 4'd0; trans_size_i = 3'd4; trans_len_i = 8'd3;
    w_valid_i = 1'b0; tx_ready_i = 1'b1;
    @(negedge clk_i);
    trans_valid_i = 1'b0;
    w_valid_i = 1'b1; w_data_i = beat_data[0]; w_strb_i = beat_strb[0]; w_last_i = 1'b1;
    cycles = 0; words_seen = 0;
    while (words_seen < 3 && cycles < 100) begin
      @(negedge clk_i);
      w_valid_i = 1'b0;
      cycles++;
      #1;
      if (tx_valid_o) words_seen++;
    end
    checkOutput("err_before_reset", err_o, 1'b1);
    checkOutput("in_send_before_reset", tx_valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rst_trans_ready", trans_ready_o, 1'b1);
    checkOutput("rst_w_ready", w_ready_o, 1'b0);
    checkOutput("rst_tx_valid", tx_valid_o, 1'b0);
    checkOutput("rst_tx_last", tx_last_o, 1'b0);
    checkOutput("rst_tx_data", tx_data_o, 16'h0000);
    checkOutput("rst_tx_mask", tx_mask_o, 2'b00);
    checkOutput("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    w_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      #1;
      checkOutput("no_tx_after_reset", tx_valid_o, 1'b0);
      checkOutput("trans_ready_after_reset", trans_ready_o, 1'b1);
    end
    w_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    trans_valid_i = 1'b0; trans_offset_i = '0; trans_size_i = '0; trans_len_i = '0;
    w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_valid_i = 1'b0; tx_ready_i = 1'b0;
    #1;
    checkOutput("reset_trans_ready", trans_ready_o, 1'b1);
    checkOutput("reset_w_ready", w_ready_o, 1'b0);
    checkOutput("reset_tx_valid", tx_valid_o, 1'b0);
    checkOutput("reset_tx_data", tx_data_o, 16'h0000);
    checkOutput("reset_err", err_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] full-width single beat");
    beat_data.delete(); beat_strb.delete();
    beat_data.push_back(128'h11ee_ddcc_bbaa_9988_7766_5544_3322_1100);
    beat_strb.push_back(16'hffff);
    applyStimulus(0, 4, 0, 0, 1'b0);

    $display("[TB] single halfword");
    beat_data.delete(); beat_strb.delete();
    beat_data.push_back(128'h0000_0000_0000_dd11_0000_0000_0000_0000);
    beat_strb.push_back(16'h0300);
    applyStimulus(8, 1, 0, 0, 1'b0);

    $display("[TB] single byte");
    beat_data.delete(); beat_strb.delete();
    beat_data.push_back(128'h0000_0000_0000_0000_0000_0000_1cab_0000);
    beat_strb.push_back(16'h0008);
    applyStimulus(3, 0, 0, 0, 1'b0);

    $display("[TB] streaming burst");
    fillRandom(1);
    applyStimulus(0, 4, 1, 1, 1'b0);

    $display("[TB] backpressure");
    fillRandom(0);
    applyStimulus(0, 4, 0, 2, 1'b0);

    $display("[TB] w_last mismatch");
    fillRandom(1);
    applyStimulus(0, 4, 1, 1, 1'b1);

    $display("[TB] reset during send");
    resetMidTransfer();

    $display("[TB] random transfers");
    for (int i = 0; i < 24; i++) begin
      automatic int off = $urandom_range(0, 15);
      automatic int sz  = $urandom_range(0, 7);
      automatic int ln  = $urandom_range(0, 3);
      fillRandom(ln);
      applyStimulus(off, sz, ln, (i % 4 == 3) ? 1 : 0, (i % 5 == 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperbus_w_serializer.md
HYPERBUS_W_SERIALIZER -- requirements
Module: hyperbus_w_serializer

Interface
REQ-001 SHALL have parameter AxiDataWidth, default 128, meaning the AXI W data width in bits; legal values are 32, 64 and 128.
REQ-002 SHALL use localparam NumLanes = AxiDataWidth/8 and LaneIdxW = log2(NumLanes).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 trans_valid_i / trans_ready_o  in/out  1  transfer-descriptor handshake.
REQ-007 trans_offset_i  in  LaneIdxW  start-address byte lane within the bus word.
REQ-008 trans_size_i  in  3  AXI size, log2 of bytes per beat.
REQ-009 trans_len_i  in  8  AXI len, number of beats minus 1.
REQ-010 w_data_i  in  AxiDataWidth, w_strb_i  in  NumLanes, w_last_i  in  1  AXI W payload.
REQ-011 w_valid_i / w_ready_o  in/out  1  W handshake.
REQ-012 tx_data_o  out  16  PHY write word; bits [7:0] carry the even byte and bits [15:8] the odd byte.
REQ-013 tx_mask_o  out  2  RWDS mask; 1 = byte not written.
REQ-014 tx_last_o  out  1  marks the final word of the transfer.
REQ-015 tx_valid_o / tx_ready_i  out/in  1  PHY handshake.
REQ-016 err_o  out  1  sticky W-last mismatch flag.

Function
REQ-017 FSM states SHALL be IDLE, LOAD and SEND.
REQ-018 trans_ready_o SHALL be 1 only in IDLE; a descriptor handshake SHALL latch offset, size and len (beats_left = len) and enter LOAD.
REQ-019 A trans_size_i greater than LaneIdxW SHALL be treated as LaneIdxW.
REQ-020 Beat window:
  - base = addr with its low size bits cleared;
  - lo = addr with bit 0 cleared;
  - hi = base + 2^size - 1;
  - if size = 0, hi = lo + 1;
  - words = (hi - lo + 1)/2.
REQ-021 addr SHALL start at trans_offset_i, and each subsequent beat SHALL use addr = (base + 2^size) mod NumLanes.
REQ-022 w_ready_o SHALL be 1 in LOAD.
REQ-023 w_ready_o SHALL also be 1 in SEND when all of the following hold: the current word is the beat's last, tx_ready_i = 1, and beats_left > 0.
REQ-024 Under REQ-023, back-to-back beats SHALL stream with no bubble.
REQ-025 A W handshake SHALL register the data and strobe and move to SEND with the word pointer at lo.
REQ-026 First-word latency SHALL be tx_valid_o = 1 in the cycle after the W handshake.
REQ-027 In SEND, tx_valid_o SHALL be 1 and tx_data_o SHALL equal lanes {ptr+1, ptr}.
REQ-028 In SEND, tx_mask_o SHALL equal the inverted strobe bits {ptr+1, ptr}.
REQ-029 Each tx handshake SHALL advance ptr by 2.
REQ-030 tx_data_o, tx_mask_o and tx_last_o SHALL stay stable while tx_valid_o = 1 and tx_ready_i = 0.
REQ-031 tx_last_o SHALL be 1 only on the final word of the beat with beats_left = 0.
REQ-032 On acceptance of the tx_last_o word, the block SHALL return to IDLE.
REQ-033 On acceptance of the final word of a beat with beats_left > 0, the block SHALL decrement beats_left.
REQ-034 In the REQ-033 case, the block SHALL go to LOAD unless a new beat was accepted in the same cycle, in which case it SHALL stay in SEND.
REQ-035 W-last mismatch: if w_last_i != (beats_left = 0) on any W handshake, err_o SHALL be set.
REQ-036 On a mismatch, the beat count SHALL still come from trans_len_i.
REQ-037 err_o SHALL clear on the next descriptor handshake.
REQ-038 When not in SEND, tx_valid_o SHALL be 0, tx_last_o SHALL be 0, and tx_data_o/tx_mask_o SHALL be don't-care.

Reset
REQ-039 rst_i SHALL force, asynchronously, state = IDLE, trans_ready_o = 1, w_ready_o = 0, tx_valid_o = 0, tx_last_o = 0, tx_data_o = 0, tx_mask_o = 0 and err_o = 0.
REQ-040 All counters SHALL reset to 0.
REQ-041 Reset asserted mid-transfer SHALL discard the transfer with no further tx words.
REQ-042 After reset deassertion, the first descriptor SHALL be accepted in the first rising edge with trans_valid_i = 1.

Verification
REQ-043 Full-width write: offset 0, size 4, len 0, strb 0xffff, data 0x11ee_ddcc_bbaa_9988_7766_5544_3322_1100 -> 8 words 0x1100, 0x3322, ..., 0x11ee, all with mask 00, tx_last_o on the 8th only.
REQ-044 Single halfword: offset 0x8, size 1, strb 0x0300, lanes 9:8 = 0xdd11 -> exactly one word 0xdd11, mask 00, tx_last_o = 1.
REQ-045 Single byte: offset 0x3, size 0, strb 0x0008, lane 3 = 0x1c -> one word {0x1c, lane 2}, mask 2'b01, tx_last_o = 1.
REQ-046 Burst with continuous ready: size 4, len 1, w_valid_i and tx_ready_i held at 1 -> 16 consecutive tx_valid_o cycles with no bubble, tx_last_o only on the 16th, and w_ready_o pulsing in the cycle of word 8.
REQ-047 Backpressure: tx_ready_i = 0 for 5 cycles mid-beat -> tx_data_o and tx_mask_o constant and the word not duplicated or lost.
REQ-048 Error and reset: len 1 with w_last_i = 1 on beat 0 -> err_o = 1 and both beats still emitted; then rst_i during SEND -> all outputs at reset values immediately and trans_ready_o = 1 after release.
